malu_iterative_unit: RTL

//  Multi-cycle RV32M execution unit; consumes the MALU_* control codes produced by ALU control decode.

---
 rtl/malu_iterative_unit_pkg.sv | 52 +++++
 rtl/malu_sign_adj.sv | 29 ++
 rtl/malu_iterative_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/malu_iterative_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// widths, MALU operation codes, FSM state encodings and decode helpers.
package malu_iterative_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [3:0] {
    MALU_MUL    = 4'd0,
    MALU_MULH   = 4'd1,
    MALU_MULHSU = 4'd2,
    MALU_MULHU  = 4'd3,
    MALU_DIV    = 4'd4,
    MALU_DIVU   = 4'd5,
    MALU_REM    = 4'd6,
    MALU_REMU   = 4'd7
  } malu_op_e;

  typedef enum logic [1:0] {
    MALU_ST_IDLE   = 2'd0,
    MALU_ST_CALC   = 2'd1,
    MALU_ST_FINISH = 2'd2
  } malu_state_e;

  function automatic logic op_known(input logic [3:0] c);
    return c[3] == 1'b0;
  endfunction

  function automatic logic op_is_div(input logic [3:0] c);
    return c[3:2] == 2'b01;
  endfunction

  function automatic logic op_is_rem(input logic [3:0] c);
    return (c == MALU_REM) || (c == MALU_REMU);
  endfunction

  // Result comes from the upper half of the product / remainder half
  function automatic logic op_sel_hi(input logic [3:0] c);
    return (c == MALU_MULH) || (c == MALU_MULHSU) || (c == MALU_MULHU) || op_is_rem(c);
  endfunction

  function automatic logic op_a_signed(input logic [3:0] c);
    return (c == MALU_MULH) || (c == MALU_MULHSU) || (c == MALU_DIV) || (c == MALU_REM);
  endfunction

  function automatic logic op_b_signed(input logic [3:0] c);
    return (c == MALU_MULH) || (c == MALU_DIV) || (c == MALU_REM);
  endfunction

endpackage

// File: rtl/malu_sign_adj.sv
// Conditional two's-complement negation of a hi/lo word pair, either as two
// independent words or as one double-width value (wide=1, negated by neg_hi).
module malu_sign_adj
  import malu_iterative_unit_pkg::*;
(
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic            neg_hi,
  input  logic            neg_lo,
  input  logic            wide,
  output logic [XLEN-1:0] hi_adj,
  output logic [XLEN-1:0] lo_adj
);

  logic [2*XLEN-1:0] pair_neg;

  always_comb begin
    pair_neg = ~{hi, lo} + (2*XLEN)'(1);
    hi_adj   = hi;
    lo_adj   = lo;
    if (wide) begin
      if (neg_hi) {hi_adj, lo_adj} = pair_neg;
    end else begin
      if (neg_hi) hi_adj = ~hi + XLEN'(1);
      if (neg_lo) lo_adj = ~lo + XLEN'(1);
    end
  end

endmodule

// File: rtl/malu_iterative_unit.sv
// Multi-cycle RV32M unit: radix-2 shift-add multiplier and restoring divider
// sharing one 2*XLEN working register, with start/busy/done handshake.
//
//   state          | meaning
//   MALU_ST_IDLE   | waiting for start; special cases resolved here
//   MALU_ST_CALC   | one multiply/divide bit per cycle, XLEN cycles
//   MALU_ST_FINISH | done_o pulse with result_o valid
module malu_iterative_unit
  import malu_iterative_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [3:0]      malu_ctrl_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  malu_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        ctrl_q;
  logic              sa_q, sb_q;
  logic [2*XLEN-1:0] pr_q;
  logic [XLEN-1:0]   opnd_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;

  logic              accept, last;
  logic              sa_in, sb_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              special_in;
  logic [XLEN-1:0]   special_res;
  logic              div_q;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, pr_step;
  logic              post_neg_hi, post_neg_lo;
  logic [XLEN-1:0]   post_hi, post_lo, final_res;

  assign accept = (state_q == MALU_ST_IDLE) && start_i && !flush_i;
  assign last   = (state_q == MALU_ST_CALC) && (cnt_q == CNT_W'(XLEN-1));
  assign sa_in  = op_a_signed(malu_ctrl_i) & op_a_i[XLEN-1];
  assign sb_in  = op_b_signed(malu_ctrl_i) & op_b_i[XLEN-1];

  malu_sign_adj u_pre (
    .hi     (op_a_i),
    .lo     (op_b_i),
    .neg_hi (sa_in),
    .neg_lo (sb_in),
    .wide   (1'b0),
    .hi_adj (mag_a),
    .lo_adj (mag_b)
  );

  // Divide-by-zero, signed overflow and unknown codes finish without iterating
  always_comb begin
    special_in  = 1'b0;
    special_res = '0;
    if (!op_known(malu_ctrl_i)) begin
      special_in = 1'b1;
    end else if (op_is_div(malu_ctrl_i)) begin
      if (op_b_i == '0) begin
        special_in  = 1'b1;
        special_res = op_is_rem(malu_ctrl_i) ? op_a_i : '1;
      end else if ((op_a_i == XMIN) && (op_b_i == '1) &&
                   ((malu_ctrl_i == MALU_DIV) || (malu_ctrl_i == MALU_REM))) begin
        special_in  = 1'b1;
        special_res = (malu_ctrl_i == MALU_DIV) ? XMIN : '0;
      end
    end
  end

  // Multiply: add multiplicand into the upper half when the low bit is set,
  // then shift the whole register right. Divide: shift left, trial-subtract.
  always_comb begin
    div_q     = op_is_div(ctrl_q);
    mul_sum   = {1'b0, pr_q[2*XLEN-1:XLEN]} + (pr_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, pr_q[XLEN-1:1]};
    div_trial = pr_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    if (!div_trial[XLEN]) div_next = {div_trial[XLEN-1:0], pr_q[XLEN-2:0], 1'b1};
    else                  div_next = {pr_q[2*XLEN-2:0], 1'b0};
    pr_step     = div_q ? div_next : mul_next;
    post_neg_hi = div_q ? sa_q : (sa_q ^ sb_q);
    post_neg_lo = div_q & (sa_q ^ sb_q);
  end

  malu_sign_adj u_post (
    .hi     (pr_step[2*XLEN-1:XLEN]),
    .lo     (pr_step[XLEN-1:0]),
    .neg_hi (post_neg_hi),
    .neg_lo (post_neg_lo),
    .wide   (!div_q),
    .hi_adj (post_hi),
    .lo_adj (post_lo)
  );

  assign final_res = op_sel_hi(ctrl_q) ? post_hi : post_lo;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= MALU_ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MALU_ST_IDLE:   if (accept) state_d = special_in ? MALU_ST_FINISH : MALU_ST_CALC;
      MALU_ST_CALC:   if (last) state_d = MALU_ST_FINISH;
      MALU_ST_FINISH: state_d = MALU_ST_IDLE;
      default:        state_d = MALU_ST_IDLE;
    endcase
    if (flush_i) state_d = MALU_ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      ctrl_q   <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      pr_q     <= '0;
      opnd_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        busy_q <= 1'b0;
      end else if (accept) begin
        ctrl_q <= malu_ctrl_i;
        sa_q   <= sa_in;
        sb_q   <= sb_in;
        cnt_q  <= '0;
        opnd_q <= op_is_div(malu_ctrl_i) ? mag_b : mag_a;
        pr_q   <= {{XLEN{1'b0}}, (op_is_div(malu_ctrl_i) ? mag_a : mag_b)};
        if (special_in) begin
          result_q <= special_res;
          done_q   <= 1'b1;
        end else begin
          busy_q <= 1'b1;
        end
      end else if (state_q == MALU_ST_CALC) begin
        pr_q  <= pr_step;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last) begin
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= final_res;
        end
      end
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
